l_transform_sequencer: RTL and testbench

- Sequences the Kuznechik (GOST R 34.12-2015) linear transform L over one 128-bit block.
- L is computed as ROUNDS applications of R, one byte per cycle, through a shared external GF(2^8) constant-multiply lookup table (registered output).
- Sits between the S-layer and the key-add stage of the round datapath.
- Owns the table port, the block handshakes and the round/byte counters.

---
 rtl/l_transform_sequencer.sv | 164 ++++++++++++++++
 tb/tb_l_transform_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l_transform_sequencer.sv
// Kuznechik linear transform L sequencer: ROUNDS R steps, one byte per cycle via an
// external registered GF(2^8) constant-multiply table. Define L_TRANSFORM_INV_EN for the inv port (L^-1).
`timescale 1ns/1ps
module l_transform_sequencer #(
  parameter int ROUNDS      = 16,
  parameter int TBL_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef L_TRANSFORM_INV_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [3:0]   tbl_coef_idx,
  output logic [7:0]   tbl_byte,
  input  logic [7:0]   tbl_result
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid stays high with out_block stable until that edge, in_ready is high only in idle.

  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [127:0]           blk_q;
  logic [7:0]             acc_q;
  logic [RW-1:0]          round_q;
  logic [3:0]             k_q;
  logic                   issuing_q;
  logic [TBL_LATENCY-1:0] vld_pipe;
  logic [TBL_LATENCY-1:0] last_pipe;

  logic         accept;
  logic         res_vld;
  logic         res_last;
  logic         final_round;
  logic [3:0]   k_dec;
  logic [7:0]   l_val;
  logic [7:0]   first_next;
  logic [127:0] op_vec;
  logic [127:0] blk_next;
  logic         inv_q;
  logic         inv_in;

`ifdef L_TRANSFORM_INV_EN
  assign inv_in = inv;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         inv_q <= 1'b0;
    else if (accept) inv_q <= inv;
  end
`else
  assign inv_in = 1'b0;
  assign inv_q  = 1'b0;
`endif

  assign accept      = (state_q == ST_IDLE) && in_valid;
  assign res_vld     = vld_pipe[TBL_LATENCY-1];
  assign res_last    = last_pipe[TBL_LATENCY-1];
  assign final_round = res_vld && res_last && (round_q == LAST_ROUND);
  assign k_dec       = k_q - 4'd1;
  assign l_val       = acc_q ^ tbl_result;

  // The inverse step feeds l the vector (a14..a0, a15); forward feeds the block as-is.
  assign op_vec     = inv_q ? {blk_q[119:0], blk_q[127:120]} : blk_q;
  assign blk_next   = inv_q ? {blk_q[119:0], l_val} : {l_val, blk_q[127:8]};
  assign first_next = inv_q ? blk_q[111:104] : l_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)    state_d = ST_RUN;
      ST_RUN:  if (final_round) state_d = ST_DONE;
      ST_DONE: if (out_ready)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    out_valid = (state_q == ST_DONE);
  end

  // Tags travel alongside each table request so results are matched without a counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= issuing_q;
      last_pipe[0] <= issuing_q && (k_q == 4'd0);
      for (int i = 1; i < TBL_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q        <= '0;
      acc_q        <= '0;
      round_q      <= '0;
      k_q          <= '0;
      issuing_q    <= 1'b0;
      tbl_coef_idx <= '0;
      tbl_byte     <= '0;
      out_block    <= '0;
    end else if (accept) begin
      blk_q        <= in_block;
      acc_q        <= '0;
      round_q      <= '0;
      k_q          <= 4'd15;
      issuing_q    <= 1'b1;
      tbl_coef_idx <= 4'd15;
      tbl_byte     <= inv_in ? in_block[119:112] : in_block[127:120];
    end else if (state_q == ST_RUN) begin
      if (issuing_q) begin
        if (k_q == 4'd0) begin
          issuing_q <= 1'b0;
        end else begin
          k_q          <= k_dec;
          tbl_coef_idx <= k_dec;
          tbl_byte     <= op_vec[{k_dec, 3'b000} +: 8];
        end
      end
      if (res_vld) begin
        if (res_last) begin
          blk_q   <= blk_next;
          acc_q   <= '0;
          round_q <= round_q + RW'(1);
          if (round_q == LAST_ROUND) begin
            out_block <= blk_next;
          end else begin
            issuing_q    <= 1'b1;
            k_q          <= 4'd15;
            tbl_coef_idx <= 4'd15;
            tbl_byte     <= first_next;
          end
        end else begin
          acc_q <= l_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_l_transform_sequencer.sv
// Bench for l_transform_sequencer: three instances (defaults, ROUNDS=1, TBL_LATENCY=3),
// each with its own table model, checked against a byte-array model of L / L^-1.
`timescale 1ns/1ps
module tb_l_transform_sequencer;

  localparam logic [127:0] COEFS = {8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
  localparam logic [127:0] VEC_IN  = 128'h64a59400000000000000000000000000;
  localparam logic [127:0] VEC_OUT = 128'hd456584dd0e3e84cc3166e4b7fa2890d;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_v  [3];
  logic         out_ready_v [3];
  logic         in_ready_v  [3];
  logic         out_valid_v [3];
  logic         busy_v      [3];
  logic [127:0] in_block_v  [3];
  logic [127:0] out_block_v [3];
  logic [3:0]   idx_v       [3];
  logic [7:0]   byte_v      [3];
  logic [7:0]   res_v       [3];
  logic [7:0]   t3a, t3b;
`ifdef L_TRANSFORM_INV_EN
  logic         inv_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l_transform_sequencer d0 (
    .clk(clk), .rst(rst),
`ifdef L_TRANSFORM_INV_EN
    .inv(inv_s),
`endif
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_block(in_block_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_block(out_block_v[0]),
    .busy(busy_v[0]), .tbl_coef_idx(idx_v[0]), .tbl_byte(byte_v[0]), .tbl_result(res_v[0])
  );

  l_transform_sequencer #(.ROUNDS(1)) d1 (
    .clk(clk), .rst(rst),
`ifdef L_TRANSFORM_INV_EN
    .inv(inv_s),
`endif
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_block(in_block_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_block(out_block_v[1]),
    .busy(busy_v[1]), .tbl_coef_idx(idx_v[1]), .tbl_byte(byte_v[1]), .tbl_result(res_v[1])
  );

  l_transform_sequencer #(.TBL_LATENCY(3)) d3 (
    .clk(clk), .rst(rst),
`ifdef L_TRANSFORM_INV_EN
    .inv(inv_s),
`endif
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .in_block(in_block_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_block(out_block_v[2]),
    .busy(busy_v[2]), .tbl_coef_idx(idx_v[2]), .tbl_byte(byte_v[2]), .tbl_result(res_v[2])
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'hC3) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input logic [3:0] k);
    logic [127:0] c;
    c = COEFS;
    return c[{k, 3'b000} +: 8];
  endfunction

  // Reference: R or R^-1 applied 'rounds' times on a 16-entry byte array (index = byte number).
  function automatic logic [127:0] ref_l(input logic [127:0] blk, input int rounds, input bit inv);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   l;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) a[k] = blk[8*k +: 8];
    for (int n = 0; n < rounds; n++) begin
      for (int k = 0; k < 16; k++) b[k] = inv ? a[(k + 15) % 16] : a[k];
      l = 8'h00;
      for (int k = 0; k < 16; k++) l = l ^ gf_mul(coef(4'(k)), b[k]);
      if (inv) begin
        for (int k = 15; k > 0; k--) a[k] = a[k-1];
        a[0] = l;
      end else begin
        for (int k = 0; k < 15; k++) a[k] = a[k+1];
        a[15] = l;
      end
    end
    for (int k = 0; k < 16; k++) r[8*k +: 8] = a[k];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int rounds_of(input int w);
    return (w == 1) ? 1 : 16;
  endfunction

  function automatic int lat_of(input int w);
    return (w == 0) ? 272 : (w == 1) ? 17 : 304;
  endfunction

  // Table models: registered output, latency 1 for d0/d1, latency 3 for d3.
  always @(posedge clk) begin
    res_v[0] <= gf_mul(coef(idx_v[0]), byte_v[0]);
    res_v[1] <= gf_mul(coef(idx_v[1]), byte_v[1]);
    t3a      <= gf_mul(coef(idx_v[2]), byte_v[2]);
    t3b      <= t3a;
    res_v[2] <= t3b;
  end

  task automatic run_block(input int w, input logic [127:0] blk,
                           output logic [127:0] res, output int lat);
    int cnt;
    @(negedge clk);
    in_block_v[w]  = blk;
    in_valid_v[w]  = 1'b1;
    out_ready_v[w] = 1'b0;
    @(negedge clk);
    in_valid_v[w] = 1'b0;
    cnt = 0;
    while (out_valid_v[w] !== 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    res = out_block_v[w];
    lat = (out_valid_v[w] === 1'b1) ? cnt : -1;
    out_ready_v[w] = 1'b1;
    @(negedge clk);
    out_ready_v[w] = 1'b0;
  endtask

  task automatic test_reset();
    for (int w = 0; w < 3; w++) begin
      checks++;
      if ({out_valid_v[w], busy_v[w], idx_v[w], byte_v[w], out_block_v[w]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got v=%b busy=%b idx=%h byte=%h blk=%h expected all 0",
                 w, out_valid_v[w], busy_v[w], idx_v[w], byte_v[w], out_block_v[w]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (in_ready_v[w] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready[%0d]: got %b expected 1", w, in_ready_v[w]);
      end
    end
  endtask

  task automatic test_vectors();
    logic [127:0] res;
    int lat;
    logic [127:0] blk [3];
    logic [127:0] exp [3];
    blk[0] = VEC_IN; exp[0] = VEC_OUT;
    blk[1] = 128'h00000000000000000000000000000100;
    exp[1] = 128'h94000000000000000000000000000001;
    blk[2] = VEC_IN; exp[2] = VEC_OUT;
    for (int w = 0; w < 3; w++) begin
      run_block(w, blk[w], res, lat);
      checks++;
      if (res !== exp[w]) begin
        errors++;
        $display("FAIL vector_result[%0d]: got %h expected %h", w, res, exp[w]);
      end
      checks++;
      if (lat != lat_of(w)) begin
        errors++;
        $display("FAIL vector_latency[%0d]: got %0d expected %0d", w, lat, lat_of(w));
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] blk, res, exp;
    int lat;
    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 3; w++) begin
        blk = rnd128();
        if (n == 0) blk = '1;
        exp = ref_l(blk, rounds_of(w), 1'b0);
        run_block(w, blk, res, lat);
        checks++;
        if (res !== exp || lat != lat_of(w)) begin
          errors++;
          $display("FAIL random[%0d] in=%h: got %h lat %0d expected %h lat %0d",
                   w, blk, res, lat, exp, lat_of(w));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b, exp, held;
    bit ok;
    int cnt;
    a = rnd128();
    b = rnd128();
    exp = ref_l(a, 16, 1'b0);
    @(negedge clk);
    out_ready_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL idle_out_ready: got v=%b busy=%b rdy=%b expected 0 0 1",
               out_valid_v[0], busy_v[0], in_ready_v[0]);
    end
    out_ready_v[0] = 1'b0;
    in_block_v[0]  = a;
    in_valid_v[0]  = 1'b1;
    @(negedge clk);
    in_block_v[0] = b;
    cnt = 0;
    while (out_valid_v[0] !== 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (out_block_v[0] !== exp || cnt != 272) begin
      errors++;
      $display("FAIL bp_result: got %h after %0d expected %h after 272", out_block_v[0], cnt, exp);
    end
    held = out_block_v[0];
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (out_block_v[0] !== held || in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_hold: got unstable output or in_ready high expected stable hold");
    end
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    checks++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b v=%b expected 1 0", in_ready_v[0], out_valid_v[0]);
    end
    ok = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (out_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_no_capture: got activity after release expected idle");
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] blk, res, exp;
    int lat;
    bit ok;
    @(negedge clk);
    in_block_v[0] = rnd128();
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid_v[0], busy_v[0], idx_v[0], byte_v[0], out_block_v[0]} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got v=%b busy=%b idx=%h byte=%h blk=%h expected all 0",
               out_valid_v[0], busy_v[0], idx_v[0], byte_v[0], out_block_v[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (350) begin
      @(negedge clk);
      if (out_valid_v[0] !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_stale: got out_valid after reset expected none");
    end
    blk = rnd128();
    exp = ref_l(blk, 16, 1'b0);
    run_block(0, blk, res, lat);
    checks++;
    if (res !== exp || lat != 272) begin
      errors++;
      $display("FAIL midrst_next: got %h lat %0d expected %h lat 272", res, lat, exp);
    end
  endtask

`ifdef L_TRANSFORM_INV_EN
  task automatic test_inverse();
    logic [127:0] x, res, exp;
    int lat;
    inv_s = 1'b1;
    run_block(0, VEC_OUT, res, lat);
    checks++;
    if (res !== VEC_IN || lat != 272) begin
      errors++;
      $display("FAIL inv_vector: got %h lat %0d expected %h lat 272", res, lat, VEC_IN);
    end
    for (int w = 0; w < 3; w++) begin
      x = rnd128();
      exp = ref_l(x, rounds_of(w), 1'b1);
      run_block(w, x, res, lat);
      checks++;
      if (res !== exp || lat != lat_of(w)) begin
        errors++;
        $display("FAIL inv_random[%0d]: got %h lat %0d expected %h lat %0d",
                 w, res, lat, exp, lat_of(w));
      end
    end
    inv_s = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
`ifdef L_TRANSFORM_INV_EN
    inv_s = 1'b0;
`endif
    for (int w = 0; w < 3; w++) begin
      in_valid_v[w]  = 1'b0;
      out_ready_v[w] = 1'b0;
      in_block_v[w]  = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_mid_reset();
`ifdef L_TRANSFORM_INV_EN
    test_inverse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
